uart_matvec_rx_engine: RTL and testbench
========================================

Name: uart_matvec_rx_engine

Overview:
- Receive path of the UART matrix-vector accelerator.
- Deserialises 8N1 UART bytes into one packed frame holding matrix K and vector x, and buffers it through a 2-entry skid buffer.
- Computes y = K·x with signed arithmetic and presents y on an AXI-Stream master for the downstream UART transmitter/width converter.

Parameters:
- CLOCKS_PER_PULSE, 20833 (200 MHz / 9600): clock cycles per UART bit.
- BITS_PER_WORD, 8: data bits per UART character.
- R, 8: matrix rows.
- C, 8: matrix columns.
- W_X, 4: signed width of each x element.
- W_K, 3: signed width of each K element.
- Derived localparams:
  - W_Y = W_X+W_K+$clog2(C) (10)
  - W_BUS_KX = R*C*W_K + C*W_X (224)
  - NUM_WORDS = ceil(W_BUS_KX/BITS_PER_WORD) (28)

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  reset, asynchronous assert, active-low.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- m_axis_y_tvalid  out  1  result valid.
- m_axis_y_tready  in  1  downstream ready.
- m_axis_y_tdata  out  R*W_Y  packed results; y[r] at bits [r*W_Y +: W_Y].

Behaviour:
- Reset values: all valids 0; all data registers 0; UART FSM IDLE; word counter 0; rx synchroniser flops 1.
- rx input passes through a 2-flop synchroniser (reset to 1) before use.
- UART FSM:
  - IDLE: on synchronised rx = 0, go to START with counter cleared.
  - START: wait CLOCKS_PER_PULSE/2 cycles, then resample. If 0, go to DATA. If 1 (glitch), return to IDLE; nothing stored.
  - DATA: sample every CLOCKS_PER_PULSE cycles, BITS_PER_WORD bits, LSB first.
  - STOP: wait CLOCKS_PER_PULSE, then sample.
    - rx = 1: the word is accepted.
    - rx = 0 (framing error): the word is discarded and the word counter is unchanged.
    - Either way, return to IDLE.
- Frame packing:
  - Each accepted word shifts into the top of a NUM_WORDS*BITS_PER_WORD shift register, moving right. The first received byte therefore ends in bits [7:0].
  - When the word counter reaches NUM_WORDS, the low W_BUS_KX bits are emitted with a 1-cycle internal rx_valid pulse and the counter wraps to 0.
  - The UART side has no backpressure. If the skid buffer is not ready on the pulse cycle, that frame is dropped.
- Frame layout:
  - K[r][c] at bits [(r*C+c)*W_K +: W_K].
  - x[c] at bits [R*C*W_K + c*W_X +: W_X].
  - All elements are two's complement.
- Skid buffer:
  - Two registers (main and skid); s_ready is registered (= skid empty).
  - Zero-bubble: full throughput when downstream is ready.
  - Data presented while valid and not ready stays stable.
- Multiplier stage:
  - s_tready = !m_axis_y_tvalid || m_axis_y_tready.
  - On a handshake, y[r] = Σc sign-extended K[r][c]*x[c], computed to W_Y bits (no overflow by construction) and registered.
  - m_axis_y_tvalid asserts the next cycle (latency 1).
  - Held with data stable until m_axis_y_tready = 1. Back-to-back accept on the ready cycle is allowed.
- Reset mid-frame discards the partial frame and all buffered/pending results. After release, the first start bit begins byte 0 of a new frame.

Optional Feature:
- Macro MVM_SVA_EN.
- Defined: concurrent assertions (disabled while !rstn) for:
  - valid && !ready |=> valid, and data stable, on the skid output;
  - the same on m_axis_y;
  - the skid buffer never overwritten when full.
- Undefined: no assertions compiled; behaviour identical.

Decomposition:
- Package mvm_pkg holds:
  - the UART FSM state enum (IDLE, START, DATA, STOP);
  - the default constants (CLOCKS_PER_PULSE, BITS_PER_WORD, R, C, W_X, W_K);
  - a width-calculation function for W_Y/W_BUS_KX.
- One natural sub-module: mvm_skid_stage (generic WIDTH 2-entry skid buffer).
- UART deserialiser and multiplier stay inline.

Test Plan:
- Use CLOCKS_PER_PULSE = 16 in sim.
- All K = 1, all x = 1, 28 bytes sent, ready high -> one beat, every y[r] = 8 (0x008), valid 1 cycle after skid handshake.
- All K = 3'b111 (-1), all x = 7 -> every y[r] = -56 (10'h3C8). Then K = -4, x = -8 -> every y[r] = 256 (10'h100).
- K = identity (K[r][r] = 1, else 0), x[c] = c-4 -> y[r] = r-4, sign-extended to 10 bits.
- m_axis_y_tready held low across 4 frames:
  - frames 1-3 are retained (output register + 2 skid entries);
  - frame 4 is dropped;
  - releasing ready yields 3 beats in order with stable data while stalled.
- rx low pulse shorter than CLOCKS_PER_PULSE/2 -> no word counted. Byte with stop bit = 0 -> discarded, frame still completes after 28 good bytes.
- Assert rstn low after 10 bytes, release, send 28 bytes -> exactly one correct result, no stale valid.

Source files
------------

// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvm_pkg
// Purpose  : Shared types, default constants and width helpers for the
//            UART matrix-vector receive engine.
// Revision : 1.0
// ============================================================================
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DEF_CLOCKS_PER_PULSE = 20833;
    localparam int DEF_BITS_PER_WORD    = 8;
    localparam int DEF_R                = 8;
    localparam int DEF_C                = 8;
    localparam int DEF_W_X              = 4;
    localparam int DEF_W_K              = 3;

    // Result width: product width plus headroom for summing C products.
    function automatic int calc_w_y(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c);
    endfunction

    function automatic int calc_w_bus_kx(input int r, input int c, input int w_k, input int w_x);
        return r * c * w_k + c * w_x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : mvm_skid_stage
// Purpose  : Generic 2-entry (main + skid) valid/ready buffer, registered
//            s_ready. Assertions compiled when MVM_SVA_EN is defined.
// Revision : 1.0
// ============================================================================
module mvm_skid_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             s_ready_q, s_ready_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             s_fire;
    logic             main_load;

    always_comb begin
        s_fire       = s_valid && s_ready_q;
        main_load    = !main_valid_q || m_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        // s_fire cannot coincide with a full skid because s_ready mirrors it.
        if (main_load) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = s_fire;
                if (s_fire) begin
                    main_data_d = s_data;
                end
            end
        end else if (s_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end
        s_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            s_ready_q    <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            s_ready_q    <= s_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = main_valid_q;
    assign m_data  = main_data_q;

`ifdef MVM_SVA_EN
    a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rstn)
        (skid_valid_q && !main_load) |=> (skid_valid_q && $stable(skid_data_q)));
`endif

endmodule
`default_nettype wire

// File: rtl/uart_matvec_rx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_matvec_rx_engine
// Purpose  : UART 8N1 frame receiver, skid buffer and signed y = K*x engine
//            with AXI-Stream result output. Optional macro: MVM_SVA_EN.
// Revision : 1.0
// ============================================================================
module uart_matvec_rx_engine
    import mvm_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int R                = DEF_R,
    parameter int C                = DEF_C,
    parameter int W_X              = DEF_W_X,
    parameter int W_K              = DEF_W_K
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                rx,
    output logic                                m_axis_y_tvalid,
    input  logic                                m_axis_y_tready,
    output logic [R*(W_X+W_K+$clog2(C))-1:0]    m_axis_y_tdata
);

    localparam int W_Y       = calc_w_y(W_X, W_K, C);
    localparam int W_BUS_KX  = calc_w_bus_kx(R, C, W_K, W_X);
    localparam int NUM_WORDS = (W_BUS_KX + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int W_SHIFT   = NUM_WORDS * BITS_PER_WORD;
    localparam int W_CNT     = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int W_BIT     = $clog2(BITS_PER_WORD + 1);
    localparam int W_WORD    = $clog2(NUM_WORDS + 1);

    localparam logic [W_CNT-1:0]  CNT_FULL  = W_CNT'(CLOCKS_PER_PULSE - 1);
    localparam logic [W_CNT-1:0]  CNT_HALF  = W_CNT'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [W_BIT-1:0]  BIT_LAST  = W_BIT'(BITS_PER_WORD - 1);
    localparam logic [W_WORD-1:0] WORD_LAST = W_WORD'(NUM_WORDS - 1);

    logic                     rx_meta_q, rx_sync_q;
    uart_state_e              state_q;
    logic [W_CNT-1:0]         cnt_q;
    logic [W_BIT-1:0]         bit_q;
    logic [BITS_PER_WORD-1:0] data_q;
    logic [W_WORD-1:0]        word_cnt_q;
    logic [W_SHIFT-1:0]       frame_q;
    logic                     rx_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
            frame_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q  <= '0;
                        data_q <= {rx_sync_q, data_q[BITS_PER_WORD-1:1]};
                        bit_q  <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx_sync_q) begin
                            frame_q <= {data_q, frame_q[W_SHIFT-1:BITS_PER_WORD]};
                            if (word_cnt_q == WORD_LAST) begin
                                word_cnt_q <= '0;
                                rx_valid_q <= 1'b1;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic                skid_s_ready;
    logic                frame_push;
    logic                kx_valid;
    logic                kx_ready;
    logic [W_BUS_KX-1:0] kx_data;

    // No UART backpressure: a frame arriving while the skid is full is lost.
    assign frame_push = rx_valid_q && skid_s_ready;

    mvm_skid_stage #(
        .WIDTH (W_BUS_KX)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (frame_push),
        .s_ready (skid_s_ready),
        .s_data  (frame_q[W_BUS_KX-1:0]),
        .m_valid (kx_valid),
        .m_ready (kx_ready),
        .m_data  (kx_data)
    );

    logic             y_valid_q, y_valid_d;
    logic [R*W_Y-1:0] y_data_q, y_data_d;
    logic [R*W_Y-1:0] y_calc;
    logic             kx_fire;

    assign kx_ready = !y_valid_q || m_axis_y_tready;
    assign kx_fire  = kx_valid && kx_ready;

    always_comb begin : mac
        logic signed [W_Y-1:0] acc;
        logic signed [W_Y-1:0] k_e;
        logic signed [W_Y-1:0] x_e;
        acc    = '0;
        k_e    = '0;
        x_e    = '0;
        y_calc = '0;
        for (int r = 0; r < R; r++) begin
            acc = '0;
            for (int c = 0; c < C; c++) begin
                k_e = W_Y'($signed(kx_data[(r*C+c)*W_K +: W_K]));
                x_e = W_Y'($signed(kx_data[R*C*W_K + c*W_X +: W_X]));
                acc = acc + k_e * x_e;
            end
            y_calc[r*W_Y +: W_Y] = acc;
        end
    end

    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        if (kx_fire) begin
            y_valid_d = 1'b1;
            y_data_d  = y_calc;
        end else if (m_axis_y_tready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
        end
    end

    assign m_axis_y_tvalid = y_valid_q;
    assign m_axis_y_tdata  = y_data_q;

`ifdef MVM_SVA_EN
    a_y_hold: assert property (@(posedge clk) disable iff (!rstn)
        (m_axis_y_tvalid && !m_axis_y_tready) |=> (m_axis_y_tvalid && $stable(m_axis_y_tdata)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_matvec_rx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_matvec_rx_engine
// Purpose  : Self-checking bench: frame table, stall, glitch/framing, reset.
// Revision : 1.0
// ============================================================================
module tb_uart_matvec_rx_engine;

    localparam int CPP = 16;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int W_Y = 10;
    localparam int NB  = 28;
    localparam int WB  = 224;
    localparam int WO  = R * W_Y;
    localparam int NV  = 7;

    typedef int kmat_t [R][C];
    typedef int xvec_t [C];
    typedef struct {
        string         name;
        logic [WB-1:0] frame;
        logic [WO-1:0] exp_y;
    } vec_t;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          rx     = 1'b1;
    logic          tready = 1'b1;
    logic          tvalid;
    logic [WO-1:0] tdata;

    int            total = 0;
    int            bad   = 0;
    logic [WO-1:0] beats [$];
    logic          stall_prev = 1'b0;
    logic [WO-1:0] data_prev  = '0;

    always #5 clk = ~clk;

    uart_matvec_rx_engine #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (8),
        .R                (R),
        .C                (C),
        .W_X              (4),
        .W_K              (3)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .rx              (rx),
        .m_axis_y_tvalid (tvalid),
        .m_axis_y_tready (tready),
        .m_axis_y_tdata  (tdata)
    );

    task automatic check(input string nm, input logic [WO-1:0] act, input logic [WO-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && tvalid && tready) beats.push_back(tdata);
        if (rstn && stall_prev) begin
            check("stall_valid", WO'(tvalid), WO'(1));
            check("stall_data", tdata, data_prev);
        end
        stall_prev = rstn && tvalid && !tready;
        data_prev  = tdata;
    end

    function automatic logic [WB-1:0] pack_frame(input kmat_t k, input xvec_t x);
        logic [WB-1:0] f;
        f = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                f[(r*C+c)*3 +: 3] = 3'(k[r][c]);
        for (int c = 0; c < C; c++)
            f[R*C*3 + c*4 +: 4] = 4'(x[c]);
        return f;
    endfunction

    function automatic logic [WO-1:0] model_y(input kmat_t k, input xvec_t x);
        logic [WO-1:0] y;
        y = '0;
        for (int r = 0; r < R; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < C; c++) s += k[r][c] * x[c];
            y[r*W_Y +: W_Y] = 10'(s);
        end
        return y;
    endfunction

    task automatic rand_kx(output kmat_t k, output xvec_t x);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                k[r][c] = int'($urandom_range(7)) - 4;
        for (int c = 0; c < C; c++) x[c] = int'($urandom_range(15)) - 8;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPP) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [WB-1:0] f);
        for (int i = 0; i < NB; i++) send_byte(f[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (beats.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic pop_check(input string nm, input logic [WO-1:0] exp);
        if (beats.size() > 0) check(nm, beats.pop_front(), exp);
        else check({nm, "_missing"}, '1, exp);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs [NV];
        kmat_t         k;
        xvec_t         x;
        logic [WB-1:0] fr [4];
        logic [WO-1:0] ye [4];
        logic [WO-1:0] e;

        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("reset_tvalid", WO'(tvalid), '0);
        check("reset_tdata", tdata, '0);
        rstn = 1'b1;
        repeat (4) @(posedge clk); #1;

        foreach (k[r, c]) k[r][c] = 1;
        foreach (x[c]) x[c] = 1;
        vecs[0].name = "ones"; vecs[0].frame = pack_frame(k, x); vecs[0].exp_y = {R{10'h008}};
        foreach (k[r, c]) k[r][c] = -1;
        foreach (x[c]) x[c] = 7;
        vecs[1].name = "neg1x7"; vecs[1].frame = pack_frame(k, x); vecs[1].exp_y = {R{10'h3C8}};
        foreach (k[r, c]) k[r][c] = -4;
        foreach (x[c]) x[c] = -8;
        vecs[2].name = "neg4neg8"; vecs[2].frame = pack_frame(k, x); vecs[2].exp_y = {R{10'h100}};
        foreach (k[r, c]) k[r][c] = (r == c) ? 1 : 0;
        foreach (x[c]) x[c] = c - 4;
        e = '0;
        for (int r = 0; r < R; r++) e[r*W_Y +: W_Y] = 10'(r - 4);
        vecs[3].name = "identity"; vecs[3].frame = pack_frame(k, x); vecs[3].exp_y = e;
        for (int i = 4; i < NV; i++) begin
            rand_kx(k, x);
            vecs[i].name = $sformatf("rand%0d", i);
            vecs[i].frame = pack_frame(k, x);
            vecs[i].exp_y = model_y(k, x);
        end

        for (int i = 0; i < NV; i++) begin
            beats.delete();
            send_frame(vecs[i].frame);
            wait_beats(1, 200);
            repeat (20) @(posedge clk); #1;
            check({vecs[i].name, "_count"}, WO'(beats.size()), WO'(1));
            pop_check(vecs[i].name, vecs[i].exp_y);
        end

        // Four frames while stalled: three held, the fourth dropped.
        beats.delete();
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_kx(k, x);
            fr[i] = pack_frame(k, x);
            ye[i] = model_y(k, x);
            send_frame(fr[i]);
        end
        repeat (20) @(posedge clk); #1;
        check("stall_no_beats", WO'(beats.size()), '0);
        check("stall_head_valid", WO'(tvalid), WO'(1));
        check("stall_head_data", tdata, ye[0]);
        tready = 1'b1;
        wait_beats(3, 100);
        repeat (200) @(posedge clk); #1;
        check("stall_count", WO'(beats.size()), WO'(3));
        pop_check("stall_beat0", ye[0]);
        pop_check("stall_beat1", ye[1]);
        pop_check("stall_beat2", ye[2]);

        // Short glitch and a framing-error byte must not count as words.
        beats.delete();
        rx = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx = 1'b1;
        repeat (3 * CPP) @(posedge clk); #1;
        send_byte(8'hA5, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rand_kx(k, x);
        send_frame(pack_frame(k, x));
        e = model_y(k, x);
        wait_beats(1, 200);
        repeat (20) @(posedge clk); #1;
        check("glitch_count", WO'(beats.size()), WO'(1));
        pop_check("glitch_data", e);

        // Reset mid-frame drops the partial frame.
        beats.delete();
        rand_kx(k, x);
        fr[0] = pack_frame(k, x);
        for (int i = 0; i < 10; i++) send_byte(fr[0][i*8 +: 8], 1'b1);
        rstn = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("midreset_tvalid", WO'(tvalid), '0);
        rstn = 1'b1;
        repeat (3) @(posedge clk); #1;
        rand_kx(k, x);
        send_frame(pack_frame(k, x));
        e = model_y(k, x);
        wait_beats(1, 200);
        repeat (50) @(posedge clk); #1;
        check("midreset_count", WO'(beats.size()), WO'(1));
        pop_check("midreset_data", e);
        check("midreset_idle", WO'(tvalid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
